// File: rtl/connect4_pkg.sv
// Shared board geometry, cell encoding and controller states
// for the connect-four win detector.
package connect4_pkg;

    localparam int COLS    = 7;
    localparam int ROWS    = 6;
    localparam int WIN_LEN = 4;
    localparam int CELLS   = COLS * ROWS;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Flat board, cell (c,r) lives at index c*ROWS+r.
    typedef logic [CELLS-1:0][1:0] board_t;

    // Off-board coordinates read as EMPTY so they never match a player.
    function automatic logic [1:0] cell_at(board_t b, int c, int r);
        logic [5:0] idx;
        idx = 6'(c * ROWS + r);
        if (c < 0 || c >= COLS || r < 0 || r >= ROWS)
            return EMPTY;
        return b[idx];
    endfunction

endpackage

// File: rtl/win_detect_line_check.sv
// Combinational four-in-a-row test along one direction through
// an anchor cell: every window containing the anchor is tried.
import connect4_pkg::*;

module line_check (
    input  board_t     board,
    input  logic [2:0] acol,
    input  logic [2:0] arow,
    input  logic [1:0] dir,
    input  logic       player,
    output logic       match
);

    int         dx;
    int         dy;
    logic       hit;
    logic [1:0] want;

    // Slide a WIN_LEN window across the anchor along (dx,dy).
    always_comb begin
        dx    = 1;
        dy    = 0;
        hit   = 1'b0;
        match = 1'b0;
        want  = player ? P2 : P1;
        case (dir)
            2'd0:    begin dx =  1; dy = 0; end
            2'd1:    begin dx =  0; dy = 1; end
            2'd2:    begin dx =  1; dy = 1; end
            default: begin dx = -1; dy = 1; end
        endcase
        for (int k = -(WIN_LEN - 1); k <= 0; k++) begin
            hit = 1'b1;
            for (int i = 0; i < WIN_LEN; i++) begin
                if (cell_at(board,
                            int'(acol) + (k + i) * dx,
                            int'(arow) + (k + i) * dy) != want)
                    hit = 1'b0;
            end
            if (hit)
                match = 1'b1;
        end
    end

endmodule

// File: rtl/win_detect.sv
// Shadow board plus a 4-direction scan run after every accepted
// coin write; reports sticky win flags, board full and errors.
import connect4_pkg::*;

module win_detect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wen,
    input  logic [2:0] col,
    input  logic [2:0] row,
    input  logic       player,
    input  logic       clear,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       win1,
    output logic       win2,
    output logic       full
);

    state_t     state_q;
    board_t     board_q;
    logic [5:0] cnt_q;
    logic [1:0] idx_q;
    logic [2:0] acol_q;
    logic [2:0] arow_q;
    logic       apl_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic       win1_q;
    logic       win2_q;
    logic       full_q;

    logic       in_range;
    logic       wr_ok;
    logic [5:0] wr_idx;
    logic       match;

    assign in_range = (col < 3'd7) && (row < 3'd6);
    assign wr_ok    = in_range && !win1_q && !win2_q &&
                      (cell_at(board_q, int'(col), int'(row)) == EMPTY);
    assign wr_idx   = 6'(int'(col) * ROWS + int'(row));

    line_check u_line_check (
        .board  (board_q),
        .acol   (acol_q),
        .arow   (arow_q),
        .dir    (idx_q),
        .player (apl_q),
        .match  (match)
    );

    // Write acceptance, scan sequencing, flag latching and clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            board_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acol_q  <= '0;
            arow_q  <= '0;
            apl_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            win1_q  <= 1'b0;
            win2_q  <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (clear) begin
                state_q <= IDLE;
                board_q <= '0;
                cnt_q   <= '0;
                idx_q   <= '0;
                busy_q  <= 1'b0;
                win1_q  <= 1'b0;
                win2_q  <= 1'b0;
                full_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (wen) begin
                            if (wr_ok) begin
                                board_q[wr_idx] <= player ? P2 : P1;
                                cnt_q   <= cnt_q + 6'd1;
                                acol_q  <= col;
                                arow_q  <= row;
                                apl_q   <= player;
                                idx_q   <= 2'd0;
                                busy_q  <= 1'b1;
                                state_q <= SCAN;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        if (match && !apl_q)
                            win1_q <= 1'b1;
                        if (match && apl_q)
                            win2_q <= 1'b1;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            done_q  <= 1'b1;
                            full_q  <= (cnt_q == 6'(CELLS));
                            state_q <= REPORT;
                        end
                    end
                    REPORT: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign win1 = win1_q;
    assign win2 = win2_q;
    assign full = full_q;

endmodule

// File: tb/tb_win_detect.sv
// Directed vector table plus hand sequences for clear,
// reset and board-fill corner cases of win_detect.
module tb_win_detect;

    logic       clk;
    logic       rst_n;
    logic       wen;
    logic [2:0] col;
    logic [2:0] row;
    logic       player;
    logic       clear;
    logic       busy;
    logic       done;
    logic       err;
    logic       win1;
    logic       win2;
    logic       full;

    int checks;
    int errors;

    typedef struct {
        bit         clr;
        logic [2:0] c;
        logic [2:0] r;
        logic       p;
        int         dn;
        bit         er;
        bit         w1;
        bit         w2;
    } vec_t;

    vec_t tv[$];

    win_detect dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wen    (wen),
        .col    (col),
        .row    (row),
        .player (player),
        .clear  (clear),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .win1   (win1),
        .win2   (win2),
        .full   (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // One write; reports the negedge index of done (0 = none)
    // and whether an err pulse was seen in 8 cycles.
    task automatic write_op(input logic [2:0] c, input logic [2:0] r,
                            input logic p, output int dn, output bit er);
        @(negedge clk);
        col = c; row = r; player = p; wen = 1'b1;
        dn = 0; er = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) wen = 1'b0;
            if (done && dn == 0) dn = k;
            if (err) er = 1'b1;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic addv(input bit clr, input int c, input int r,
                        input int p, input int dn, input bit er,
                        input bit w1, input bit w2);
        vec_t v;
        v.clr = clr; v.c = 3'(c); v.r = 3'(r); v.p = p[0];
        v.dn = dn; v.er = er; v.w1 = w1; v.w2 = w2;
        tv.push_back(v);
    endtask

    initial begin
        int  dn;
        bit  er;
        int  nd;
        bit  busy_seen;
        checks = 0; errors = 0;
        rst_n = 1'b0; wen = 1'b0; col = '0; row = '0;
        player = 1'b0; clear = 1'b0;

        // horizontal P1 win, P2 parked on column 6
        addv(0, 0, 0, 0, 5, 0, 0, 0);
        addv(0, 6, 0, 1, 5, 0, 0, 0);
        addv(0, 1, 0, 0, 5, 0, 0, 0);
        addv(0, 6, 1, 1, 5, 0, 0, 0);
        addv(0, 2, 0, 0, 5, 0, 0, 0);
        addv(0, 6, 2, 1, 5, 0, 0, 0);
        addv(0, 3, 0, 0, 5, 0, 1, 0);
        addv(0, 6, 3, 1, 0, 1, 1, 0);
        // occupied cell and range errors
        addv(1, 2, 0, 0, 5, 0, 0, 0);
        addv(0, 2, 0, 1, 0, 1, 0, 0);
        addv(0, 7, 0, 0, 0, 1, 0, 0);
        addv(0, 0, 6, 0, 0, 1, 0, 0);
        // diagonal P2 win with support coins
        addv(1, 0, 0, 1, 5, 0, 0, 0);
        addv(0, 1, 0, 0, 5, 0, 0, 0);
        addv(0, 1, 1, 1, 5, 0, 0, 0);
        addv(0, 2, 0, 0, 5, 0, 0, 0);
        addv(0, 2, 1, 0, 5, 0, 0, 0);
        addv(0, 2, 2, 1, 5, 0, 0, 0);
        addv(0, 3, 0, 0, 5, 0, 0, 0);
        addv(0, 3, 1, 0, 5, 0, 0, 0);
        addv(0, 3, 2, 0, 5, 0, 0, 0);
        addv(0, 3, 3, 1, 5, 0, 0, 1);
        addv(0, 4, 0, 0, 0, 1, 0, 1);

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_win1", win1, 0);
        chk("rst_win2", win2, 0);
        chk("rst_full", full, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            if (tv[i].clr) do_clear();
            write_op(tv[i].c, tv[i].r, tv[i].p, dn, er);
            chk($sformatf("v%0d_done_at", i), dn, tv[i].dn);
            chk($sformatf("v%0d_err", i), int'(er), int'(tv[i].er));
            chk($sformatf("v%0d_win1", i), win1, int'(tv[i].w1));
            chk($sformatf("v%0d_win2", i), win2, int'(tv[i].w2));
        end

        // draw fill, one rejected rewrite in the middle
        do_clear();
        nd = 0;
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                write_op(3'(c), 3'(r), 1'(((r / 2) + c) % 2), dn, er);
                nd++;
                chk($sformatf("fill%0d_done_at", nd), dn, 5);
                if (nd == 20) begin
                    write_op(3'd0, 3'd0, 1'b1, dn, er);
                    chk("fill_occ_err", int'(er), 1);
                    chk("fill_occ_done", dn, 0);
                end
                if (nd == 41) chk("fill41_full", full, 0);
            end
        end
        chk("fill42_full", full, 1);
        chk("fill_win1", win1, 0);
        chk("fill_win2", win2, 0);
        write_op(3'd0, 3'd0, 1'b0, dn, er);
        chk("fill43_err", int'(er), 1);
        chk("fill43_done", dn, 0);

        // clear two cycles after wen aborts the scan
        do_clear();
        chk("clr_full", full, 0);
        @(negedge clk);
        col = 3'd4; row = 3'd0; player = 1'b0; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        chk("mid_busy", busy, 1);
        @(negedge clk);
        clear = 1'b1;
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            clear = 1'b0;
            if (k == 0) chk("abort_busy", busy, 0);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        write_op(3'd4, 3'd0, 1'b1, dn, er);
        chk("abort_board_empty", dn, 5);

        // clear and wen together: write discarded
        @(negedge clk);
        col = 3'd5; row = 3'd0; player = 1'b0;
        wen = 1'b1; clear = 1'b1;
        @(negedge clk);
        wen = 1'b0; clear = 1'b0;
        chk("cw_busy", busy, 0);
        chk("cw_err", err, 0);
        write_op(3'd5, 3'd0, 1'b1, dn, er);
        chk("cw_discarded", dn, 5);
        chk("cw_err2", int'(er), 0);

        // reset mid-scan, then a fresh write
        do_clear();
        @(negedge clk);
        col = 3'd1; row = 3'd0; player = 1'b0; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        @(negedge clk);
        busy_seen = busy;
        chk("pre_rst_busy", int'(busy_seen), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", err, 0);
        chk("mrst_full", full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        write_op(3'd1, 3'd0, 1'b1, dn, er);
        chk("post_rst_done_at", dn, 5);
        chk("post_rst_err", int'(er), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
